// File: rtl/scroll_seg_driver.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | scroll_seg_driver: multiplexed 7-segment driver scrolling a window over a   |
// | writable message buffer of 4-bit character codes.  Rev 1.0                  |
// +----------------------------------------------------------------------------+
module scroll_seg_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int MSG_LEN     = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 25000000,
    parameter int BLANK_CYC   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [3:0]                 wr_data,
    input  logic                       scroll_en,
    input  logic                       dir,
    input  logic                       step,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [7:0]                 ca,
    output logic [$clog2(MSG_LEN)-1:0] offset,
    output logic                       wrap
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int IW = AW + DW + 1;

    logic [RW-1:0]         refresh_q, refresh_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [SW-1:0]         scroll_q, scroll_d;
    logic [AW-1:0]         offset_q, offset_d;
    logic                  wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            ca_q, ca_d;
    logic [3:0]            msg_q [MSG_LEN];
    logic [3:0]            msg_d [MSG_LEN];

    logic                  scroll_tick;
    logic                  advance;
    logic [IW-1:0]         idx_sum;
    logic [AW-1:0]         idx;

    function automatic logic [7:0] seg_decode(input logic [3:0] c);
        case (c)
            4'd1:    seg_decode = 8'b11100011;
            4'd2:    seg_decode = 8'b10000011;
            4'd3:    seg_decode = 8'b01100011;
            4'd4:    seg_decode = 8'b10011111;
            4'd5:    seg_decode = 8'b01110001;
            4'd6:    seg_decode = 8'b01100001;
            4'd7:    seg_decode = 8'b01110011;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    always_comb begin
        refresh_d = refresh_q + RW'(1);
        digit_d   = digit_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + DW'(1);
        end
    end

    // A tick coinciding with step is still a single advance.
    always_comb begin
        scroll_tick = scroll_en && (scroll_q == SW'(SCROLL_DIV - 1));
        scroll_d    = scroll_q;
        if (scroll_en) begin
            scroll_d = scroll_tick ? '0 : scroll_q + SW'(1);
        end
        advance  = scroll_tick | step;
        offset_d = offset_q;
        wrap_d   = 1'b0;
        if (advance) begin
            if (!dir) begin
                if (offset_q == AW'(MSG_LEN - 1)) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q + AW'(1);
                end
            end else begin
                if (offset_q == '0) begin
                    offset_d = AW'(MSG_LEN - 1);
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q - AW'(1);
                end
            end
        end
    end

    always_comb begin
        msg_d = msg_q;
        if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN))) begin
            msg_d[wr_addr] = wr_data;
        end
    end

    // Sum is below 2*MSG_LEN, so one conditional subtract gives the modulo.
    always_comb begin
        idx_sum = IW'(offset_q) + IW'(NUM_DIGITS - 1) - IW'(digit_q);
        idx     = (idx_sum >= IW'(MSG_LEN)) ? AW'(idx_sum - IW'(MSG_LEN)) : AW'(idx_sum);
        an_d    = '1;
        ca_d    = 8'hFF;
        if (refresh_q >= RW'(BLANK_CYC)) begin
            an_d[digit_q] = 1'b0;
            ca_d          = seg_decode(msg_q[idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            digit_q   <= '0;
            scroll_q  <= '0;
            offset_q  <= '0;
            wrap_q    <= 1'b0;
            an_q      <= '1;
            ca_q      <= 8'hFF;
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= '0;
            end
        end else begin
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            scroll_q  <= scroll_d;
            offset_q  <= offset_d;
            wrap_q    <= wrap_d;
            an_q      <= an_d;
            ca_q      <= ca_d;
            msg_q     <= msg_d;
        end
    end

    assign an     = an_q;
    assign ca     = ca_q;
    assign offset = offset_q;
    assign wrap   = wrap_q;

endmodule
`default_nettype wire

// File: doc/scroll_seg_driver.md
Name: scroll_seg_driver

Overview:
- Parametrised multiplexed 7-segment scrolling-text driver for the Nexys 4 DDR 8-digit display.
- Holds a writable message buffer of 4-bit character codes and scrolls a NUM_DIGITS-wide window across it, left or right, with a programmable rate.
- Time-multiplexes the anodes with anti-ghosting blanking and decodes characters to active-low segments internally.
- Sits between the top-level text/control logic and the board's an/ca pins.

Parameters:
- NUM_DIGITS, 8: number of physical digits; an width. Must be ≥1.
- MSG_LEN, 16: message buffer depth in characters. Must be ≥ NUM_DIGITS and ≥2.
- REFRESH_DIV, 100000: clocks per digit slot. Must be > BLANK_CYC.
- SCROLL_DIV, 25000000: clocks per automatic scroll step. Must be ≥1.
- BLANK_CYC, 4: clocks at the start of each digit slot with all anodes off.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe for the message buffer
- wr_addr  in  $clog2(MSG_LEN)  buffer write address; writes with wr_addr ≥ MSG_LEN are ignored
- wr_data  in  4  character code
- scroll_en  in  1  enables automatic scrolling
- dir  in  1  0 = scroll left (offset increments), 1 = scroll right (offset decrements)
- step  in  1  single-cycle manual advance pulse
- an  out  NUM_DIGITS  active-low digit enables; an[0] is the rightmost digit
- ca  out  8  active-low segments, bit7..bit0 = a,b,c,d,e,f,g,h (h = decimal point)
- offset  out  $clog2(MSG_LEN)  message index shown on the leftmost digit
- wrap  out  1  one-cycle pulse when offset wraps

Behaviour:
- Reset is asynchronous and applies immediately, including mid-operation. It sets:
  - an = all 1s, ca = 8'hFF, offset = 0, wrap = 0
  - every buffer entry = 0 (blank)
  - refresh counter = 0, digit index = 0, scroll counter = 0
- Character decode (active-low):
  - 0 = blank, 8'b11111111
  - 1 = l, 8'b11100011
  - 2 = u, 8'b10000011
  - 3 = c, 8'b01100011
  - 4 = i, 8'b10011111
  - 5 = f, 8'b01110001
  - 6 = e, 8'b01100001
  - 7 = r, 8'b01110011
  - 8–15 = blank
- Refresh:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index k advances 0→1→…→NUM_DIGITS-1→0.
- Digit content: digit k shows msg[(offset + NUM_DIGITS-1-k) mod MSG_LEN], so the leftmost digit shows msg[offset].
- Outputs (registered every clock from the current counter state):
  - While the refresh counter < BLANK_CYC: an = all 1s, ca = 8'hFF.
  - Otherwise: an = all 1s except an[k] = 0; ca = decode of digit k's character.
- Latency: a buffer write, offset change or digit change appears on an/ca at the first clock edge after the register updates, i.e. 1 cycle.
- Scroll counter:
  - Counts 0..SCROLL_DIV-1 only while scroll_en = 1.
  - Holds its value (not cleared) while scroll_en = 0.
  - The terminal count generates a scroll tick.
- Advance:
  - An advance occurs on a scroll tick or a step pulse. Coincident tick and step produce exactly one advance.
  - step is honoured regardless of scroll_en.
  - dir = 0: offset ← (offset == MSG_LEN-1) ? 0 : offset+1; wrap = 1 on the MSG_LEN-1→0 transition.
  - dir = 1: offset ← (offset == 0) ? MSG_LEN-1 : offset-1; wrap = 1 on the 0→MSG_LEN-1 transition.
  - wrap is registered and high for exactly the cycle in which offset takes its wrapped value.
  - dir is sampled at the advance; changing dir never itself moves offset.
- Buffer writes:
  - A write takes effect at the clock edge.
  - A write to an entry currently on screen is visible one cycle later.
  - Writes are independent of refresh and scroll state.
- Held step: held high for multiple cycles, step advances once per cycle; the bench drives single-cycle pulses.

Test Plan:
All scenarios use NUM_DIGITS=4, MSG_LEN=8, REFRESH_DIV=8, SCROLL_DIV=32, BLANK_CYC=2.
- Reset/blanking: assert rst_n=0 mid-slot → an=4'b1111, ca=8'hFF and offset=0 immediately (no clock). Release → cycles 0–1 of each slot show an=1111; cycles 2–7 show one an bit low, cycling an=1110,1101,1011,0111 per 8-cycle slot (digit index 0 first, then 1, 2, 3).
- Decode/placement: write msg[0..7] = 1,2,3,4,5,6,7,0 with offset=0 → an[3]=0 shows ca=11100011 (l); an[0]=0 shows ca=10011111 (i).
- Auto-scroll left with wrap: scroll_en=1, dir=0 → offset increments every 32 cycles; the step 7→0 pulses wrap for 1 cycle; at offset=6 the leftmost digit shows r (01110011) and the rightmost shows u (code 2 → 10000011).
- Hold, step and coincidence: scroll_en=0 for 100 cycles → offset constant, scroll counter frozen. step pulse with dir=1 at offset=0 → offset=7 and wrap=1. step coincident with a scroll tick → offset changes by exactly 1.
- Live write: overwrite the entry shown on the active digit with code 4 → ca=10011111 one cycle later. Write with wr_addr ≥ 8 is ignored (not possible at MSG_LEN=8; exercise with MSG_LEN=6).
